// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: FSM state encoding and the
// per-stage writer record flags.
package hazard_scoreboard_pkg;

    // RUN: normal flow. MC_WAIT: a multi-cycle op sits in EX awaiting mc_done.
    typedef enum logic {
        SB_RUN     = 1'b0,
        SB_MC_WAIT = 1'b1
    } sb_state_e;

    // Flag part of a slot record; rd is carried alongside at the
    // parameterised register-index width.
    typedef struct packed {
        logic v;     // valid register writer (never set for rd=x0)
        logic load;  // instruction is a load
        logic mc;    // instruction is a multi-cycle EX op
    } slot_flags_t;

endpackage

// File: rtl/sb_stage_slot.sv
// One pipeline-stage record {v, rd, load, mc}. Priority: clear, hold, load;
// with none of those asserted the slot takes a bubble (all zero).
module sb_stage_slot
    import hazard_scoreboard_pkg::*;
#(
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           clear,
    input  logic                           hold,
    input  logic                           load,
    input  slot_flags_t                    d_flags,
    input  logic [REGISTER_ADDR_WIDTH-1:0] d_rd,
    output slot_flags_t                    q_flags,
    output logic [REGISTER_ADDR_WIDTH-1:0] q_rd
);

    // Record register: clear wins, hold keeps contents, otherwise load or bubble.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every slot sample its neighbour's
        // pre-edge value, which is what turns EX->MEM->WB into a clean shift.
        if (clear) begin
            q_flags <= '0;
            q_rd    <= '0;
        end else if (!hold) begin
            if (load) begin
                q_flags <= d_flags;
                q_rd    <= d_rd;
            end else begin
                q_flags <= '0;
                q_rd    <= '0;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Writer-side scoreboard for the five-stage core: tracks issued writers
// through EX/MEM/WB, publishes MEM/WB writers to the forwarding detector,
// and produces stall/bubble/hold controls for load-use and mul/div hazards.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int STALL_CNT_WIDTH     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_rs2,
    input  logic                           id_uses_rs1,
    input  logic                           id_uses_rs2,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_rd,
    input  logic                           id_reg_write,
    input  logic                           id_is_load,
    input  logic                           id_is_mc,
    input  logic                           mc_done,
    input  logic                           ex_flush,
    output logic                           stall_ID,
    output logic                           bubble_EX,
    output logic                           hold_EX,
    output logic                           reg_write_MEM,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM,
    output logic                           reg_write_WB,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_WB,
    output logic [STALL_CNT_WIDTH-1:0]     stall_cycles
);

    sb_state_e                      state;
    slot_flags_t                    id_flags, ex_flags, mem_flags, wb_flags;
    logic [REGISTER_ADDR_WIDTH-1:0] id_rd_rec, ex_rd, mem_rd, wb_rd;
    logic                           id_writes;
    logic                           load_use;
    logic                           mc_busy;
    logic                           issue;

    // x0 is never recorded as a writer; its rd is zeroed too so a
    // non-writer can never match a consumer's source index.
    assign id_writes = id_reg_write & (id_rd != '0);
    assign id_rd_rec = id_writes ? id_rd : '0;
    assign id_flags  = '{v: id_writes, load: id_is_load, mc: id_is_mc};

    assign load_use = id_valid & ex_flags.v & ex_flags.load &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

    // A multi-cycle op is still computing; an mc_done pulse releases it this cycle.
    assign mc_busy = (state == SB_MC_WAIT) & ~mc_done;

    // Pipeline controls: mc wait overrides everything (a flush here is a
    // protocol violation and is ignored); otherwise flush beats load-use.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned and infers a latch.
        stall_ID  = 1'b0;
        bubble_EX = 1'b0;
        hold_EX   = 1'b0;
        if (mc_busy) begin
            stall_ID = 1'b1;
            hold_EX  = 1'b1;
        end else begin
            stall_ID  = load_use & ~ex_flush;
            bubble_EX = load_use | ex_flush;
        end
    end

    assign issue = id_valid & ~stall_ID & ~ex_flush;

    sb_stage_slot #(.REGISTER_ADDR_WIDTH(REGISTER_ADDR_WIDTH)) u_ex_slot (
        .clk     (clk),
        .clear   (rst),
        .hold    (hold_EX),
        .load    (issue),
        .d_flags (id_flags),
        .d_rd    (id_rd_rec),
        .q_flags (ex_flags),
        .q_rd    (ex_rd)
    );

    // While EX holds, MEM takes a bubble so the held op is not duplicated.
    sb_stage_slot #(.REGISTER_ADDR_WIDTH(REGISTER_ADDR_WIDTH)) u_mem_slot (
        .clk     (clk),
        .clear   (rst),
        .hold    (1'b0),
        .load    (~hold_EX),
        .d_flags (ex_flags),
        .d_rd    (ex_rd),
        .q_flags (mem_flags),
        .q_rd    (mem_rd)
    );

    // WB always advances from MEM so older writers drain during a hold.
    sb_stage_slot #(.REGISTER_ADDR_WIDTH(REGISTER_ADDR_WIDTH)) u_wb_slot (
        .clk     (clk),
        .clear   (rst),
        .hold    (1'b0),
        .load    (1'b1),
        .d_flags (mem_flags),
        .d_rd    (mem_rd),
        .q_flags (wb_flags),
        .q_rd    (wb_rd)
    );

    // Forwarding-facing outputs are taken directly from slot registers.
    assign reg_write_MEM = mem_flags.v;
    assign rd_MEM        = mem_rd;
    assign reg_write_WB  = wb_flags.v;
    assign rd_WB         = wb_rd;

    // Flags that no consumer downstream of EX needs.
    logic unused_slot_flags;
    assign unused_slot_flags = ^{ex_flags.mc, mem_flags.load, mem_flags.mc,
                                 wb_flags.load, wb_flags.mc};

    // FSM: enter MC_WAIT on the edge an mc op enters EX, leave on mc_done
    // unless a back-to-back mc op issues in that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SB_RUN;
        end else if (issue & id_is_mc) begin
            state <= SB_MC_WAIT;
        end else if ((state == SB_MC_WAIT) & mc_done) begin
            state <= SB_RUN;
        end
    end

    // Saturating count of cycles spent with ID stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_ID & (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Writer-side companion of the forwarding network in the five-stage RISC-V core.
- Records every issued register writer and tracks it through EX, MEM and WB.
- Drives the rd/reg_write signals that the forwarding detector compares against.
- Generates the stall, bubble and hold controls for load-use hazards and for multi-cycle EX operations (mul/div).

Parameters:
REGISTER_ADDR_WIDTH, 5, architectural register index width
STALL_CNT_WIDTH, 32, width of the saturating stall-cycle performance counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  valid instruction present in ID
id_rs1  in  REGISTER_ADDR_WIDTH  ID source register 1
id_rs2  in  REGISTER_ADDR_WIDTH  ID source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_rd  in  REGISTER_ADDR_WIDTH  ID destination register
id_reg_write  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
id_is_mc  in  1  ID instruction is a multi-cycle EX op
mc_done  in  1  one-cycle pulse from the multi-cycle unit: result ready
ex_flush  in  1  redirect from EX: discard the instruction in ID
stall_ID  out  1  freeze PC and IF/ID registers
bubble_EX  out  1  load a NOP into ID/EX
hold_EX  out  1  freeze ID/EX contents (multi-cycle op in progress)
reg_write_MEM  out  1  valid writer in MEM
rd_MEM  out  REGISTER_ADDR_WIDTH  destination register of the MEM writer
reg_write_WB  out  1  valid writer in WB
rd_WB  out  REGISTER_ADDR_WIDTH  destination register of the WB writer
stall_cycles  out  STALL_CNT_WIDTH  count of cycles with stall_ID=1

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset clears all slots, sets state RUN and zeroes stall_cycles.
  - Consequently every output is 0 during and after reset.
  - Reset mid-operation, including MC_WAIT, discards everything with no drain.
- Slot record, for each of EX, MEM and WB: {v, rd, load, mc}.
  - v = id_reg_write & (id_rd != 0) at capture. rd=x0 is never recorded.
  - A non-writing mc op is still tracked, with v=0 and mc=1, so the FSM sees it.
- Issue: id_valid & !stall_ID & !ex_flush. The instruction is captured into the EX slot at the next edge.
  - Otherwise the EX slot loads a bubble (all zero), except while hold_EX.
- Normal advance each edge: EX→MEM→WB→retired.
  - Latency: issued at edge N gives MEM at N+1, WB at N+2, retired at N+3.
- Outputs reg_write_MEM/rd_MEM/reg_write_WB/rd_WB come straight from slot registers, with zero combinational logic.
- load_use = id_valid & EX.v & EX.load & ((id_uses_rs1 & id_rs1==EX.rd) | (id_uses_rs2 & id_rs2==EX.rd)).
- FSM states:
  - RUN:
    - stall_ID = load_use.
    - bubble_EX = load_use | ex_flush.
    - hold_EX = 0.
    - An issue with id_is_mc moves to MC_WAIT at the same edge the op enters EX.
  - MC_WAIT:
    - If !mc_done: hold_EX=1, stall_ID=1, bubble_EX=0.
      - The EX slot holds.
      - MEM loads a bubble.
      - WB advances from MEM normally, so older writers drain.
    - If mc_done: behave as RUN for this cycle and move to RUN.
      - EX advances to MEM.
      - ID may issue, including back-to-back mc ops, which re-enter MC_WAIT.
      - load_use is still checked.
- Simultaneous events:
  - ex_flush beats load_use: ID is discarded, stall_ID=0, bubble_EX=1.
  - ex_flush while in MC_WAIT with !mc_done is a protocol violation. A bench assertion catches it, and the RTL ignores the flush.
  - mc_done outside MC_WAIT is ignored.
- stall_cycles increments each cycle stall_ID=1 and saturates at all-ones with no wrap.

Decomposition:
- Shared package/header (riscv_defs.vh):
  - slot-field widths
  - FSM state encodings SB_RUN=0 and SB_MC_WAIT=1
- One natural sub-module: sb_stage_slot.
  - A register for one {v, rd, load, mc} record.
  - Controls: load, hold and clear.
  - Instantiated three times.

Test Plan:
1. Back-to-back ALU writers:
   - Stimulus: issue x5 then x6 on consecutive cycles.
   - Response: rd_MEM=5 and reg_write_MEM=1 one cycle after the first issue, then rd_MEM=6 with rd_WB=5. No stalls.
2. Load-use:
   - Stimulus: issue load x7, then ID has rs2=x7 with uses_rs2=1.
   - Response: stall_ID=1 and bubble_EX=1 for exactly 1 cycle. Next cycle the load is in MEM, the consumer issues, and stall_cycles=1.
3. rd=x0 and unused source:
   - Stimulus: load to x0 followed by rs1=x0; separately, a load to x7 followed by rs1=x7 with uses_rs1=0.
   - Response: no stall in either case, and reg_write_MEM=0 for the x0 load.
4. Multi-cycle op:
   - Stimulus: issue a mc op writing x9, with mc_done on the 4th cycle in MC_WAIT.
   - Response: hold_EX=1 and stall_ID=1 for 3 cycles. rd_MEM=9 on the cycle after mc_done. The older writer reaches WB during the hold.
5. Flush priority:
   - Stimulus: load_use and ex_flush in the same cycle.
   - Response: stall_ID=0, bubble_EX=1, and the EX slot is empty next cycle.
6. Reset in MC_WAIT:
   - Stimulus: rst pulse while holding.
   - Response: next cycle all outputs are 0, the state is RUN, and a new issue proceeds normally.
